// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit                                                 |
// | Description : Instruction-fetch front end. Drives the synchronous        |
// |               instruction memory, tracks its one-cycle read latency and  |
// |               queues returned words with their PCs for decode.           |
// |               Optional macro FETCH_PERF_CNT_EN adds perf_fetched and     |
// |               perf_redirects event counters.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INST_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_pc,
  output logic                  imem_stall,
  input  logic [INST_WIDTH-1:0] imem_inst,
  output logic                  out_valid,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_redirects
`endif
);

  localparam int c_ptr_w = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(QUEUE_DEPTH + 1);
  localparam int c_occ_w = c_cnt_w + 1;

  localparam logic [ADDR_WIDTH-1:0] c_pc_step  = ADDR_WIDTH'(4);
  localparam logic [c_ptr_w-1:0]    c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]    c_cnt_full = c_cnt_w'(QUEUE_DEPTH);
  localparam logic [c_occ_w-1:0]    c_occ_lim  = c_occ_w'(QUEUE_DEPTH);

  // Fetch / in-flight request state
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_req_valid;
  logic [ADDR_WIDTH-1:0] r_req_pc;

  // Queue state
  logic [INST_WIDTH-1:0] r_inst_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc_q   [QUEUE_DEPTH];
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_cnt_w-1:0]    r_count;

  logic [c_occ_w-1:0]    w_occupancy;
  logic                  w_issue;
  logic                  w_enq;
  logic                  w_deq;
  logic [ADDR_WIDTH-1:0] w_next_pc;

  // A slot is reserved for the in-flight word; a same-cycle dequeue is not credited.
  assign w_occupancy = {1'b0, r_count} + c_occ_w'(r_req_valid);
  assign w_issue     = redirect_valid | (w_occupancy < c_occ_lim);

  assign imem_pc     = redirect_valid ? redirect_pc : r_fetch_pc;
  assign imem_stall  = ~w_issue;
  assign w_next_pc   = imem_pc + c_pc_step;

  assign w_enq       = r_req_valid & ~redirect_valid;
  assign w_deq       = out_valid & out_ready;

  assign out_valid   = (r_count != '0);
  assign out_inst    = r_inst_q[r_rd_ptr];
  assign out_pc      = r_pc_q[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (w_issue) begin
      r_fetch_pc  <= w_next_pc;
      r_req_valid <= 1'b1;
      r_req_pc    <= imem_pc;
    end else begin
      r_req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset only, so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_inst_q[i] <= '0;
        r_pc_q[i]   <= '0;
      end
    end else if (w_enq) begin
      r_inst_q[r_wr_ptr] <= imem_inst;
      r_pc_q[r_wr_ptr]   <= r_req_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_redirects;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
    end else begin
      if (w_enq) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        r_perf_redirects <= r_perf_redirects + 32'd1;
      end
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_redirects = r_perf_redirects;
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_enq && !w_deq && (r_count == c_cnt_full)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                              |
// | Description : Directed self-checking bench for fetch_unit with a         |
// |               one-cycle synchronous memory model.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic        imem_stall;
  logic [31:0] imem_inst = '0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .RESET_PC   (32'h0),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_pc       (imem_pc),
    .imem_stall    (imem_stall),
    .imem_inst     (imem_inst),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_ready     (out_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_redirects(perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  // Memory word is derived from its address so inst and pc can be told apart.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (!imem_stall) imem_inst <= inst_of(imem_pc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, out_inst, inst_of(pc));
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;          // cycle 0
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_imem_pc", imem_pc, 32'h0);
    check("rst_stall", {31'b0, imem_stall}, 32'd0);

    // Streaming: first valid at cycle 2, one PC per cycle
    cyc(1'b0, '0, 1'b1);                     // cycle 1
    check("lat_valid_c1", {31'b0, out_valid}, 32'd0);
    for (int k = 2; k <= 7; k++) begin
      cyc(1'b0, '0, 1'b1);
      head("stream", 32'(4 * (k - 2)));
    end

    // Backpressure: out_ready low cycles 8..17
    cyc(1'b0, '0, 1'b0);                     // 8
    check("bp_stall_c8", {31'b0, imem_stall}, 32'd0);
    cyc(1'b0, '0, 1'b0);                     // 9
    cyc(1'b0, '0, 1'b0);                     // 10
    check("bp_stall_c10", {31'b0, imem_stall}, 32'd1);
    check("bp_imem_pc_c10", imem_pc, 32'h28);
    repeat (6) cyc(1'b0, '0, 1'b0);          // 11..16
    cyc(1'b0, '0, 1'b0);                     // 17
    check("bp_stall_c17", {31'b0, imem_stall}, 32'd1);
    head("bp_hold", 32'h18);
    cyc(1'b0, '0, 1'b1);                     // 18: dequeue not credited
    check("bp_stall_c18", {31'b0, imem_stall}, 32'd1);
    head("bp_c18", 32'h18);
    cyc(1'b0, '0, 1'b1);                     // 19
    check("bp_stall_c19", {31'b0, imem_stall}, 32'd0);
    check("bp_imem_pc_c19", imem_pc, 32'h28);
    head("bp_c19", 32'h1c);
    cyc(1'b0, '0, 1'b1); head("bp_c20", 32'h20);
    cyc(1'b0, '0, 1'b1); head("bp_c21", 32'h24);
    cyc(1'b0, '0, 1'b1); head("bp_c22", 32'h28);

    // Redirect with 3 queued + 1 in flight
    cyc(1'b0, '0, 1'b0);                     // 23
    cyc(1'b1, 32'h100, 1'b0);                // 24
    check("rd_imem_pc", imem_pc, 32'h100);
    check("rd_stall", {31'b0, imem_stall}, 32'd0);
    head("rd_old_head", 32'h2c);
    cyc(1'b0, '0, 1'b1);                     // 25
    check("rd_flushed", {31'b0, out_valid}, 32'd0);
    cyc(1'b0, '0, 1'b1); head("rd_h0", 32'h100);
    cyc(1'b0, '0, 1'b1); head("rd_h1", 32'h104);
    cyc(1'b0, '0, 1'b1); head("rd_h2", 32'h108);

    // Fill the queue, then redirect with a coincident dequeue
    cyc(1'b0, '0, 1'b0);                     // 29
    cyc(1'b0, '0, 1'b0);                     // 30
    cyc(1'b0, '0, 1'b0);                     // 31
    check("full_stall", {31'b0, imem_stall}, 32'd1);
    check("full_imem_pc", imem_pc, 32'h11c);
    cyc(1'b1, 32'h100, 1'b1);                // 32
    head("rdq_head", 32'h10c);
    check("rdq_imem_pc", imem_pc, 32'h100);
    check("rdq_stall", {31'b0, imem_stall}, 32'd0);
    cyc(1'b0, '0, 1'b1);                     // 33
    check("rdq_empty", {31'b0, out_valid}, 32'd0);
    cyc(1'b0, '0, 1'b1); head("rdq_h0", 32'h100);

    // Address wrap
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1);          // 35
    check("wrap_imem_pc", imem_pc, 32'hFFFF_FFFC);
    cyc(1'b0, '0, 1'b1);
    check("wrap_empty", {31'b0, out_valid}, 32'd0);
    cyc(1'b0, '0, 1'b1); head("wrap_h0", 32'hFFFF_FFFC);
    cyc(1'b0, '0, 1'b1); head("wrap_h1", 32'h0);
    cyc(1'b0, '0, 1'b1); head("wrap_h2", 32'h4);

    // Reset mid-operation wins over redirect and handshake
    @(negedge clk); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; out_ready = 1'b1;
    @(negedge clk); rst = 1'b0; redirect_valid = 1'b0; #1;
    check("mrst_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_out_pc", out_pc, 32'h0);
    check("mrst_out_inst", out_inst, 32'h0);
    check("mrst_imem_pc", imem_pc, 32'h0);
    check("mrst_stall", {31'b0, imem_stall}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched_rst", perf_fetched, 32'd0);
    check("perf_redirects_rst", perf_redirects, 32'd0);
`endif

    // 20 enqueues, then two redirect cycles
    repeat (20) cyc(1'b0, '0, 1'b1);
    head("perf_stream", 32'h48);
    cyc(1'b1, 32'h40, 1'b1);
    cyc(1'b1, 32'h40, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("perf_gap", {31'b0, out_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd20);
    check("perf_redirects", perf_redirects, 32'd2);
`endif
    cyc(1'b0, '0, 1'b1); head("perf_h0", 32'h40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that sits directly upstream of the synchronous instruction memory and directly downstream-feeds decode. Generates the fetch PC, drives the memory's address and stall inputs, tracks the one-cycle memory read latency, and buffers returned instructions with their PCs in a small FIFO exposed to decode through a valid/ready handshake. Branch/exception redirects flush all buffered and in-flight work and restart fetch at the new PC with no bubble cycle.

## Interface
- ADDR_WIDTH, 32, PC/address width
- INST_WIDTH, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- QUEUE_DEPTH, 4, FIFO entries; power of two, ≥2

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address, word aligned
- imem_pc  out  ADDR_WIDTH  address to instruction memory (combinational)
- imem_stall  out  1  1 = memory holds its output register
- imem_inst  in  INST_WIDTH  memory output, valid the cycle after an issue
- out_valid  out  1  FIFO head valid
- out_inst  out  INST_WIDTH  FIFO head instruction
- out_pc  out  ADDR_WIDTH  FIFO head PC
- out_ready  in  1  decode accepts head this cycle

## Operation
- State: fetch_pc, req_valid_q (request in flight), req_pc_q, FIFO (rd_ptr, wr_ptr, count 0..QUEUE_DEPTH).
- issue = redirect_valid | ((count + req_valid_q) < QUEUE_DEPTH). Dequeue in the same cycle is not credited.
- imem_pc = redirect_valid ? redirect_pc : fetch_pc; imem_stall = ~issue.
- On issue: req_valid_q <= 1, req_pc_q <= imem_pc, fetch_pc <= imem_pc + 4 (mod 2^ADDR_WIDTH). No issue: req_valid_q <= 0, fetch_pc held.
- Enqueue: when req_valid_q=1 and no redirect this cycle, write {imem_inst, req_pc_q} at wr_ptr.
- Dequeue: out_valid & out_ready; rd_ptr advances. Pointers wrap mod QUEUE_DEPTH.
- Redirect (priority over all else): count, rd_ptr, wr_ptr <= 0; in-flight response discarded (no enqueue); redirect_pc issued same cycle. A dequeue handshake coinciding with redirect still completes; decode squashes it.
- Simultaneous enqueue+dequeue: count unchanged. Enqueue never overflows (guaranteed by issue rule); an overflow is a design error flagged by assertion.
- out_valid = (count != 0); out_inst/out_pc read directly from head entry.

## Timing
- Reset values: fetch_pc=RESET_PC, req_valid_q=0, count=0, pointers=0 → out_valid=0, out_inst/out_pc=0 (storage cleared), imem_pc=RESET_PC, imem_stall=0 in first post-reset cycle.
- Issue at cycle N → instruction in FIFO at edge ending N+1 → out_valid in N+2. Redirect at N → head is redirect_pc at N+2.
- Sustained throughput 1 instruction/cycle with out_ready held high.
- Reset mid-operation clears everything at the next edge regardless of redirect or handshake.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs perf_fetched (32-bit, +1 per enqueue) and perf_redirects (32-bit, +1 per redirect_valid cycle), both wrap at 2^32, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, out_ready=1, memory returns word=addr: out_valid first at cycle 2; out_pc 0x0,0x4,0x8,… one per cycle, out_inst matching.
- out_ready=0 for 10 cycles: count reaches 4, imem_stall=1 while count+inflight=4, no lost/duplicated PCs after out_ready returns.
- Redirect to 0x100 with 3 entries queued and one in flight: next cycle out_valid=0; cycle after head out_pc=0x100, then 0x104; stale PCs never appear.
- Redirect and dequeue same cycle with full FIFO: handshake completes, FIFO empty next cycle, imem_pc=0x100 in redirect cycle.
- Redirect to 0xFFFFFFFC: out_pc sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
- With FETCH_PERF_CNT_EN: 20 fetches + 2 redirects → perf_fetched and perf_redirects equal enqueue and redirect counts exactly (redirects=2).
